// File: rtl/c432_pattern_loader_if.sv
// Serial-in and response handshake bundle between the pattern loader and its host.
interface c432_pattern_loader_if #(
  parameter int unsigned N_PO = 7
) ();
  logic            sin_valid;
  logic            sin_data;
  logic            sin_ready;
  logic            resp_valid;
  logic            resp_ready;
  logic [N_PO-1:0] resp_data;

  // Host side: streams input bits, consumes responses
  modport master (
    output sin_valid, sin_data, resp_ready,
    input  sin_ready, resp_valid, resp_data
  );

  // Loader side
  modport slave (
    input  sin_valid, sin_data, resp_ready,
    output sin_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/c432_pattern_loader.sv
// c432 stimulus/response front end: serial vector load, parallel apply,
// settle, capture, handshake out, MISR signature and pattern count.
module c432_pattern_loader #(
  parameter int unsigned N_PI          = 36,
  parameter int unsigned N_PO          = 7,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  c432_pattern_loader_if.slave    bus,
  output logic [N_PI-1:0]         o_pi_vec,
  input  logic [N_PO-1:0]         i_po_vec,
  input  logic                    i_sig_clr,
  output logic [15:0]             o_signature,
  output logic [15:0]             o_pat_count
);

  localparam int unsigned CNT_W = $clog2(N_PI);
  localparam int unsigned SET_W = 8;
  localparam int unsigned SIG_W = 16;
  localparam logic [SIG_W-1:0] MISR_POLY = 16'h1021;
  localparam logic [SIG_W-1:0] CNT_MAX   = 16'hFFFF;

  typedef enum logic [1:0] {
    S_SHIFT   = 2'd0,
    S_APPLY   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_bitcnt;
  logic [N_PI-2:0]    r_shift;
  logic [N_PI-1:0]    r_pi_vec;
  logic [SET_W-1:0]   r_settle;
  logic [N_PO-1:0]    r_resp_data;
  logic [SIG_W-1:0]   r_sig;
  logic [SIG_W-1:0]   r_cnt;

  logic               w_accept;
  logic               w_last_bit;
  logic               w_settled;
  logic               w_resp_take;
  logic [SIG_W-1:0]   w_sig_nxt;

  assign w_accept    = (r_state == S_SHIFT) && bus.sin_valid;
  assign w_last_bit  = (r_bitcnt == CNT_W'(N_PI - 1));
  assign w_settled   = (r_settle <= SET_W'(1));
  assign w_resp_take = (r_state == S_RESP) && bus.resp_ready;
  assign w_sig_nxt   = {r_sig[SIG_W-2:0], 1'b0}
                     ^ (r_sig[SIG_W-1] ? MISR_POLY : '0)
                     ^ SIG_W'(i_po_vec);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_SHIFT;
    else     r_state <= w_state_nxt;
  end

  // Next-state and handshake decode
  always_comb begin
    w_state_nxt    = r_state;
    bus.sin_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    unique case (r_state)
      S_SHIFT: begin
        bus.sin_ready = 1'b1;
        if (w_accept && w_last_bit) w_state_nxt = S_APPLY;
      end
      S_APPLY: begin
        if (w_settled) w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        bus.resp_valid = 1'b1;
        if (w_resp_take) w_state_nxt = S_SHIFT;
      end
      default: w_state_nxt = S_SHIFT;
    endcase
  end

  // Serial assembly; the applied vector only changes on the final bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_pi_vec <= '0;
      r_settle <= '0;
    end else if (w_accept) begin
      if (w_last_bit) begin
        r_pi_vec <= {bus.sin_data, r_shift};
        r_bitcnt <= '0;
        r_settle <= SET_W'(SETTLE_CYCLES);
      end else begin
        r_shift[r_bitcnt] <= bus.sin_data;
        r_bitcnt          <= r_bitcnt + CNT_W'(1);
      end
    end else if (r_state == S_APPLY) begin
      r_settle <= r_settle - SET_W'(1);
    end
  end

  // Response capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       r_resp_data <= '0;
    else if (r_state == S_CAPTURE) r_resp_data <= i_po_vec;
  end

  // Signature and pattern count; a clear overrides a coincident capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sig <= '0;
      r_cnt <= '0;
    end else if (i_sig_clr) begin
      r_sig <= '0;
      r_cnt <= '0;
    end else if (r_state == S_CAPTURE) begin
      r_sig <= w_sig_nxt;
      if (r_cnt != CNT_MAX) r_cnt <= r_cnt + SIG_W'(1);
    end
  end

  assign bus.resp_data = r_resp_data;
  assign o_pi_vec      = r_pi_vec;
  assign o_signature   = r_sig;
  assign o_pat_count   = r_cnt;

endmodule

// File: tb/tb_c432_pattern_loader.sv
// Scoreboard bench for c432_pattern_loader with a behavioural core and MISR model.
module tb_c432_pattern_loader;

  localparam int unsigned N_PI   = 36;
  localparam int unsigned N_PO   = 7;
  localparam int unsigned SETTLE = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N_PI-1:0]   pi_vec;
  logic [N_PO-1:0]   po_vec;
  logic              sig_clr = 1'b0;
  logic [15:0]       signature;
  logic [15:0]       pat_count;

  logic              force_en  = 1'b0;
  logic [N_PO-1:0]   force_val = '0;
  int                rdy_mode  = 0;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [N_PO-1:0] resp;
    logic [15:0]     sig;
    logic [15:0]     cnt;
    logic [N_PI-1:0] pi;
  } exp_t;
  exp_t sb_q[$];

  int unsigned m_sig = 0;
  int unsigned m_cnt = 0;

  c432_pattern_loader_if #(.N_PO(N_PO)) bus ();

  c432_pattern_loader #(
    .N_PI(N_PI), .N_PO(N_PO), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .o_pi_vec   (pi_vec),
    .i_po_vec   (po_vec),
    .i_sig_clr  (sig_clr),
    .o_signature(signature),
    .o_pat_count(pat_count)
  );

  always #5 clk = ~clk;

  // Stand-in for the c432 core: parity of rotating masks, key bit folded in
  function automatic logic [N_PO-1:0] core_fn(input logic [N_PI-1:0] v);
    logic [N_PI-1:0] m;
    logic [N_PO-1:0] o;
    m = 36'h9_A3C5_71E2;
    for (int i = 0; i < N_PO; i++) begin
      o[i] = (^(v & m)) ^ v[N_PI-1];
      m = {m[30:0], m[35:31]};
    end
    return o;
  endfunction

  always_comb po_vec = force_en ? force_val : core_fn(pi_vec);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic fail_now(input string nm);
    n_total++;
    $display("FAIL %s: bound expired at %0t", nm, $time);
  endtask

  // Reference: one captured pattern updates MISR and count, then queue the response
  task automatic model_push(input logic [N_PI-1:0] v, input logic [N_PO-1:0] po, input bit clr);
    exp_t e;
    if (clr) begin
      m_sig = 0;
      m_cnt = 0;
    end else begin
      m_sig = (m_sig * 2) ^ (((m_sig >> 15) & 1) != 0 ? 32'h1021 : 32'h0) ^ int'(po);
      m_sig = m_sig % 65536;
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
    end
    e.resp = po;
    e.sig  = 16'(m_sig);
    e.cnt  = 16'(m_cnt);
    e.pi   = v;
    sb_q.push_back(e);
  endtask

  // Monitor: every handshake pops one expected response
  always @(negedge clk) begin
    if (!rst && bus.resp_valid && bus.resp_ready) begin
      if (sb_q.size() == 0) begin
        fail_now("unexpected_resp");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("resp_data", 64'(bus.resp_data), 64'(e.resp));
        chk("signature", 64'(signature), 64'(e.sig));
        chk("pat_count", 64'(pat_count), 64'(e.cnt));
        chk("pi_vec",    64'(pi_vec),    64'(e.pi));
      end
    end
  end

  // Consumer ready: 0 = always, 1 = random, 2 = stalled
  initial begin
    bus.resp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.resp_ready = 1'b1;
        1:       bus.resp_ready = 1'($urandom_range(0, 1));
        default: bus.resp_ready = 1'b0;
      endcase
    end
  end

  // Present one bit, scrambling data while the loader is not accepting
  task automatic put_bit(input logic b, input bit gaps);
    int t;
    if (gaps && ($urandom_range(0, 99) < 30)) begin
      bus.sin_valid = 1'b0;
      bus.sin_data  = 1'($urandom);
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    bus.sin_valid = 1'b1;
    bus.sin_data  = 1'($urandom);
    t = 0;
    forever begin
      @(negedge clk);
      if (bus.sin_ready) begin
        bus.sin_data = b;
        break;
      end
      bus.sin_data = 1'($urandom);
      t++;
      if (t > 1000) begin
        fail_now("sin_ready_wait");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "loader never accepted input");
      end
    end
    @(posedge clk);
    #1;
    bus.sin_valid = 1'b0;
  endtask

  task automatic send_vec(input logic [N_PI-1:0] v, input bit gaps);
    for (int i = 0; i < N_PI; i++) put_bit(v[i], gaps);
  endtask

  task automatic wait_resp_valid();
    int t;
    t = 0;
    while (!bus.resp_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.resp_valid) fail_now("resp_valid_wait");
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    if (sb_q.size() != 0) fail_now("drain");
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_pi_vec"},     64'(pi_vec),         64'h0);
    chk({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'h0);
    chk({tag, "_resp_data"},  64'(bus.resp_data),  64'h0);
    chk({tag, "_signature"},  64'(signature),      64'h0);
    chk({tag, "_pat_count"},  64'(pat_count),      64'h0);
    chk({tag, "_sin_ready"},  64'(bus.sin_ready),  64'h1);
  endtask

  initial begin
    logic [N_PI-1:0] v;
    logic [N_PI-1:0] pv;
    bus.sin_valid = 1'b0;
    bus.sin_data  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset");
    rst = 1'b0;

    // Alternating vector, fixed core response, latency to resp_valid
    force_en  = 1'b1;
    force_val = 7'h55;
    rdy_mode  = 0;
    v = 36'h5_5555_5555;
    for (int i = 0; i < N_PI; i++) begin
      put_bit(v[i], 1'b0);
      if (i == 20 || i == 34) chk("pi_hold_during_shift", 64'(pi_vec), 64'h0);
    end
    chk("pi_after_last_bit", 64'(pi_vec), 64'h5_5555_5555);
    model_push(v, 7'h55, 1'b0);
    @(posedge clk); #1;
    chk("resp_valid_e1", 64'(bus.resp_valid), 64'h0);
    @(posedge clk); #1;
    chk("resp_valid_e2", 64'(bus.resp_valid), 64'h0);
    @(posedge clk); #1;
    chk("resp_valid_e3", 64'(bus.resp_valid), 64'h1);
    drain();
    chk("sig_first", 64'(signature), 64'h0055);

    // Second pattern under a stalled consumer
    force_val = 7'h2A;
    rdy_mode  = 2;
    v = N_PI'({$urandom, $urandom});
    send_vec(v, 1'b0);
    model_push(v, 7'h2A, 1'b0);
    wait_resp_valid();
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("stall_resp_valid", 64'(bus.resp_valid), 64'h1);
      chk("stall_sin_ready",  64'(bus.sin_ready),  64'h0);
      chk("stall_resp_data",  64'(bus.resp_data),  64'h2A);
    end
    rdy_mode = 0;
    drain();
    chk("sig_second", 64'(signature), 64'h0080);
    chk("cnt_second", 64'(pat_count), 64'h2);

    // Random vectors through the core model, gappy input, random ready
    force_en = 1'b0;
    rdy_mode = 1;
    for (int n = 0; n < 20; n++) begin
      v = N_PI'({$urandom, $urandom});
      send_vec(v, 1'b1);
      model_push(v, core_fn(v), 1'b0);
    end
    drain();
    rdy_mode = 0;

    // Clear coincident with capture
    force_en  = 1'b1;
    force_val = 7'h33;
    v = N_PI'({$urandom, $urandom});
    send_vec(v, 1'b0);
    model_push(v, 7'h33, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    sig_clr = 1'b1;
    @(posedge clk); #1;
    sig_clr = 1'b0;
    drain();
    force_en = 1'b0;

    // Reset in the middle of shifting
    pv = N_PI'({$urandom, $urandom});
    for (int i = 0; i <= 20; i++) put_bit(pv[i], 1'b0);
    #2 rst = 1'b1;
    #1;
    check_cleared("rst_shift");
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    m_sig = 0;
    m_cnt = 0;
    v = N_PI'({$urandom, $urandom});
    send_vec(v, 1'b0);
    model_push(v, core_fn(v), 1'b0);
    drain();

    // Reset while a response is pending
    rdy_mode = 2;
    send_vec(N_PI'({$urandom, $urandom}), 1'b0);
    wait_resp_valid();
    #2 rst = 1'b1;
    #1;
    check_cleared("rst_resp");
    @(posedge clk); #1;
    rst = 1'b0;
    rdy_mode = 0;
    sb_q.delete();
    m_sig = 0;
    m_cnt = 0;
    v = N_PI'({$urandom, $urandom});
    send_vec(v, 1'b0);
    model_push(v, core_fn(v), 1'b0);
    drain();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/c432_pattern_loader.md
Name: c432_pattern_loader

Overview:
- Sequential stimulus/response front end for the c432 combinational core: serially loads a 36-bit primary-input vector, including the key bit at position 35, and applies it to the core in parallel.
- After a programmable settle window it captures the core's 7 primary outputs and presents them through a valid/ready handshake.
- Captured responses are folded into a 16-bit MISR signature; applied patterns are counted. Used for oracle querying of locked c432 instances.

Parameters:
N_PI, 36, primary-input width (fixed for c432; index 35 = key input N115)
N_PO, 7, primary-output width (N223,N329,N370,N421,N430,N431,N432 -> po_vec[0..6])
SETTLE_CYCLES, 2, cycles pi_vec is held before capture; legal range 1..255

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
sin_valid  in  1  serial input bit valid
sin_data  in  1  serial input bit
sin_ready  out  1  loader accepts a serial bit this cycle
pi_vec  out  N_PI  parallel vector to core; index order N1,N4,N8,...,N112,N115
po_vec  in  N_PO  core outputs (combinational from pi_vec)
resp_valid  out  1  resp_data valid
resp_ready  in  1  consumer accepts resp_data
resp_data  out  N_PO  captured po_vec
sig_clr  in  1  synchronous clear of signature and pattern count
signature  out  16  MISR state
pat_count  out  16  captured-pattern count, saturating

Behaviour:
- Reset (async, immediate): state=SHIFT; bit counter=0; shift reg, pi_vec, resp_data, signature, pat_count all 0; resp_valid=0; sin_ready=1 once state is SHIFT.
- A reset mid-operation discards any partial vector or pending response.
- States: SHIFT, APPLY, CAPTURE, RESP.
- SHIFT:
  - sin_ready=1. Each cycle with sin_valid=1 stores sin_data into shift reg bit[bitcnt] and increments bitcnt. The first accepted bit maps to pi_vec[0] (N1).
  - pi_vec does NOT change while shifting; it holds the previously applied vector.
  - On acceptance of bit 35: pi_vec <= full vector with bit 35 = last sin_data; bitcnt <= 0; settle counter <= SETTLE_CYCLES; go to APPLY.
- APPLY: sin_ready=0. Settle counter decrements each cycle. When it reaches 1, go to CAPTURE. APPLY therefore lasts exactly SETTLE_CYCLES cycles.
- CAPTURE (one cycle):
  - resp_data <= po_vec.
  - signature <= {sig[14:0],0} ^ (sig[15] ? 16'h1021 : 0) ^ {9'b0, po_vec}.
  - pat_count increments, saturating at 16'hFFFF.
  - Go to RESP.
- RESP:
  - resp_valid=1 with resp_data stable.
  - On resp_valid && resp_ready, go to SHIFT; resp_valid drops the next cycle.
  - While resp_ready=0 the loader stalls indefinitely.
- Latency: the edge accepting bit 35 updates pi_vec. Capture occurs at that edge + SETTLE_CYCLES + 1. resp_valid is asserted after that capture edge.
- sin_valid is ignored outside SHIFT (sin_ready=0); no bits are lost or queued.
- sig_clr (any state): signature <= 0 and pat_count <= 0. If coincident with CAPTURE, the clear wins for both signature and pat_count, but resp_data is still loaded and the handshake proceeds.
- pi_vec remains at the last applied vector through SHIFT of the next pattern, so core outputs are stable between patterns.

Test Plan:
- Reset, then shift 36 bits of 1010... (bit0=1) -> pi_vec = 36'h5_5555_5555 one cycle after the 36th bit; pi_vec stays 0 during bits 0..34.
- po_vec tied 7'h55, SETTLE_CYCLES=2, resp_ready=1 -> resp_valid rises 3 edges after pi_vec update; resp_data=7'h55; signature=16'h0055; pat_count=1.
- Second pattern with po_vec=7'h2A -> signature=16'h0080, pat_count=2; resp_ready held 0 for 5 cycles keeps resp_valid=1, sin_ready=0, resp_data stable.
- sin_valid toggled with gaps during SHIFT, and held 1 during APPLY/RESP -> only bits accepted in SHIFT are stored; pi_vec matches exactly 36 accepted bits.
- sig_clr asserted in the CAPTURE cycle -> signature=0, pat_count=0, resp_data still = po_vec.
- rst asserted mid-SHIFT (bit 20) and mid-RESP -> all outputs 0 immediately; the next 36 bits form a complete fresh vector.
